// File: rtl/lcd_scroll_ctrl.sv
// Scrolls a 16-character window of a message buffer across LCD line 1.
// A host write port shares the display write path and always wins.
`timescale 1ns/1ps
module lcd_scroll_ctrl #(
    parameter int MSG_DEPTH    = 64,
    parameter int SCROLL_TICKS = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       msg_we,
    input  logic [5:0] msg_addr,
    input  logic [7:0] msg_din,
    input  logic [6:0] msg_len,
    input  logic       host_we,
    input  logic [4:0] host_addr,
    input  logic [7:0] host_din,
    output logic       lcd_w,
    output logic [4:0] lcd_wadd,
    output logic [7:0] lcd_din,
    output logic [5:0] offset,
    output logic       frame_done,
    output logic       busy
);
    // state | meaning
    // IDLE  | scrolling off, tick counter held at zero
    // WAIT  | counting down to the next frame start
    // RD    | buffer read of the current window character
    // WR    | display write of that character (stalls on host_we)
    typedef enum logic [1:0] {IDLE, WAIT, RD, WR} state_t;

    localparam int              CW      = $clog2(SCROLL_TICKS + 1);
    localparam logic [CW-1:0]   RELOAD  = CW'(SCROLL_TICKS - 1);
    localparam logic [6:0]      MAX_LEN = 7'(MSG_DEPTH);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [6:0]    len, len_nxt;
    logic [5:0]    offset_nxt;
    logic [5:0]    ptr, ptr_nxt;
    logic [3:0]    col, col_nxt;
    logic          lcd_w_nxt;
    logic [4:0]    lcd_wadd_nxt;
    logic [7:0]    lcd_din_nxt;
    logic          frame_done_nxt;
    logic [6:0]    len_in, ptr_inc, off_inc;

    logic [7:0]    mem [MSG_DEPTH];
    logic [7:0]    rd_data;

    // Buffer contents are deliberately not reset; reads see live contents.
    always_ff @(posedge clk) begin
        if (msg_we)
            mem[msg_addr] <= msg_din;
        if (state == RD)
            rd_data <= mem[ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            len        <= '0;
            offset     <= '0;
            ptr        <= '0;
            col        <= '0;
            lcd_w      <= 1'b0;
            lcd_wadd   <= '0;
            lcd_din    <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            len        <= len_nxt;
            offset     <= offset_nxt;
            ptr        <= ptr_nxt;
            col        <= col_nxt;
            lcd_w      <= lcd_w_nxt;
            lcd_wadd   <= lcd_wadd_nxt;
            lcd_din    <= lcd_din_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        len_nxt        = len;
        offset_nxt     = offset;
        ptr_nxt        = ptr;
        col_nxt        = col;
        lcd_w_nxt      = 1'b0;
        lcd_wadd_nxt   = lcd_wadd;
        lcd_din_nxt    = lcd_din;
        frame_done_nxt = 1'b0;
        len_in         = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
        ptr_inc        = {1'b0, ptr} + 7'd1;
        off_inc        = {1'b0, offset} + 7'd1;

        if (host_we) begin
            lcd_w_nxt    = 1'b1;
            lcd_wadd_nxt = host_addr;
            lcd_din_nxt  = host_din;
        end

        // Counter saturates at zero so an overrun frame restarts at once.
        if (state != IDLE && cnt != '0)
            cnt_nxt = cnt - CW'(1);

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        len_nxt = len_in;
                        cnt_nxt = RELOAD;
                        if (len_in != 7'd0) begin
                            if ({1'b0, offset} >= len_in) begin
                                offset_nxt = '0;
                                ptr_nxt    = '0;
                            end else begin
                                ptr_nxt = offset;
                            end
                            col_nxt   = '0;
                            state_nxt = RD;
                        end
                    end
                end
                RD: state_nxt = WR;
                WR: begin
                    if (!host_we) begin
                        lcd_w_nxt    = 1'b1;
                        lcd_wadd_nxt = {1'b0, col};
                        lcd_din_nxt  = rd_data;
                        ptr_nxt      = (ptr_inc == len) ? 6'd0 : ptr_inc[5:0];
                        if (col == 4'd15) begin
                            offset_nxt     = (off_inc == len) ? 6'd0 : off_inc[5:0];
                            frame_done_nxt = 1'b1;
                            state_nxt      = WAIT;
                        end else begin
                            col_nxt   = col + 4'd1;
                            state_nxt = RD;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == RD) || (state == WR);

endmodule

// File: tb/tb_lcd_scroll_ctrl.sv
// Directed bench for lcd_scroll_ctrl: frames, wrap, short/zero length,
// host collisions, enable drop and mid-frame reset.
`timescale 1ns/1ps
module tb_lcd_scroll_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       msg_we;
    logic [5:0] msg_addr;
    logic [7:0] msg_din;
    logic [6:0] msg_len;
    logic       host_we;
    logic [4:0] host_addr;
    logic [7:0] host_din;
    logic       lcd_w;
    logic [4:0] lcd_wadd;
    logic [7:0] lcd_din;
    logic [5:0] offset;
    logic       frame_done;
    logic       busy;

    lcd_scroll_ctrl #(.MSG_DEPTH(64), .SCROLL_TICKS(100)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .msg_we(msg_we), .msg_addr(msg_addr), .msg_din(msg_din), .msg_len(msg_len),
        .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
        .lcd_w(lcd_w), .lcd_wadd(lcd_wadd), .lcd_din(lcd_din),
        .offset(offset), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    string msg_ref = "ABCDEFGHIJKLMNOPQRST";

    // Display shadow and cumulative write counts, captured mid-cycle.
    logic [7:0] disp [32];
    int wcnt [32];
    int wtot = 0;
    int fd_cnt = 0;
    int base_wcnt [32];
    int base_tot, base_fd;
    int dc1, dc2, dc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_w === 1'b1) begin
            disp[lcd_wadd] <= lcd_din;
            wcnt[lcd_wadd] <= wcnt[lcd_wadd] + 1;
            wtot           <= wtot + 1;
        end
        if (frame_done === 1'b1)
            fd_cnt <= fd_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 32; i++) base_wcnt[i] = wcnt[i];
        base_tot = wtot;
        base_fd  = fd_cnt;
    endtask

    task automatic wait_busy(input int budget);
        int n = 0;
        while (busy !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        chk("busy_seen", 32'(busy), 1);
    endtask

    task automatic wait_done(input int budget, output int done_cyc);
        int n = 0;
        while (frame_done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        done_cyc = cyc;
        chk("frame_done_seen", 32'(frame_done), 1);
        step(1);
    endtask

    task automatic check_line(input string tag, input int start, input int len);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] e;
            e = msg_ref[(start + i) % len];
            chk($sformatf("%s_char%0d", tag, i), 32'(disp[i]), 32'(e));
            chk($sformatf("%s_cnt%0d", tag, i), wcnt[i] - base_wcnt[i], 1);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; msg_we = 1'b0; msg_addr = '0; msg_din = '0;
        msg_len = 7'd20; host_we = 1'b0; host_addr = '0; host_din = '0;
        step(3);
        rst_n = 1'b1;
        step(1);
        chk("rst_lcd_w", 32'(lcd_w), 0);
        chk("rst_lcd_wadd", 32'(lcd_wadd), 0);
        chk("rst_lcd_din", 32'(lcd_din), 0);
        chk("rst_offset", 32'(offset), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_busy", 32'(busy), 0);

        for (int i = 0; i < 64; i++) begin
            msg_we = 1'b1; msg_addr = 6'(i); msg_din = 8'h20; step(1);
        end
        for (int i = 0; i < 20; i++) begin
            msg_addr = 6'(i); msg_din = 8'(msg_ref[i]); step(1);
        end
        msg_we = 1'b0;

        // First frame follows enable almost immediately, then every 100 cycles.
        snap();
        enable = 1'b1;
        wait_done(60, dc1);
        check_line("f1", 0, 20);
        chk("f1_offset", 32'(offset), 1);
        chk("f1_fd_pulse_width", 32'(frame_done), 0);
        chk("f1_total", wtot - base_tot, 16);
        chk("f1_fd_count", fd_cnt - base_fd, 1);
        snap();
        wait_done(120, dc2);
        check_line("f2", 1, 20);
        chk("f2_period", dc2 - dc1, 100);
        chk("f2_offset", 32'(offset), 2);

        // Asynchronous reset while in WR.
        wait_busy(150);
        step(1);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        chk("mid_rst_lcd_w", 32'(lcd_w), 0);
        chk("mid_rst_lcd_din", 32'(lcd_din), 0);
        chk("mid_rst_offset", 32'(offset), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        step(2);
        rst_n = 1'b1;
        snap();
        step(150);
        chk("idle_no_writes", wtot - base_tot, 0);

        // Advance to offset 19, then check the wrap frame.
        enable = 1'b1;
        for (int k = 0; k < 19; k++) wait_done(120, dc);
        chk("pre_wrap_offset", 32'(offset), 19);
        snap();
        wait_done(120, dc);
        check_line("wrap", 19, 20);
        chk("wrap_offset", 32'(offset), 0);

        // Short message repeats cyclically.
        enable = 1'b0;
        step(1);
        msg_len = 7'd5;
        for (int i = 0; i < 5; i++) begin
            msg_we = 1'b1; msg_addr = 6'(i); msg_din = 8'(msg_ref[i]); step(1);
        end
        msg_we = 1'b0;
        snap();
        enable = 1'b1;
        wait_done(60, dc);
        check_line("len5", 0, 5);
        chk("len5_offset", 32'(offset), 1);

        // Zero length: no frames.
        msg_len = 7'd0;
        snap();
        step(300);
        chk("len0_writes", wtot - base_tot, 0);
        chk("len0_fd", fd_cnt - base_fd, 0);
        chk("len0_offset", 32'(offset), 1);
        chk("len0_busy", 32'(busy), 0);

        // Host write collides with a scroll WR for three cycles.
        msg_len = 7'd20;
        snap();
        wait_busy(150);
        step(1);
        host_we = 1'b1; host_addr = 5'd20; host_din = 8'h41;
        step(1);
        chk("host_lcd_w", 32'(lcd_w), 1);
        chk("host_lcd_wadd", 32'(lcd_wadd), 20);
        chk("host_lcd_din", 32'(lcd_din), 32'h41);
        chk("host_stall_busy", 32'(busy), 1);
        step(2);
        host_we = 1'b0;
        wait_done(60, dc);
        check_line("host", 1, 20);
        chk("host_cnt", wcnt[20] - base_wcnt[20], 3);
        chk("host_data", 32'(disp[20]), 32'h41);
        chk("host_total", wtot - base_tot, 19);

        // Drop enable at col 7 (in WR), then re-enable.
        snap();
        wait_busy(150);
        step(15);
        enable = 1'b0;
        step(50);
        chk("drop_total", wtot - base_tot, 7);
        chk("drop_col6", wcnt[6] - base_wcnt[6], 1);
        chk("drop_col6_char", 32'(disp[6]), 32'h49);
        chk("drop_col7", wcnt[7] - base_wcnt[7], 0);
        chk("drop_offset", 32'(offset), 2);
        chk("drop_fd", fd_cnt - base_fd, 0);
        chk("drop_busy", 32'(busy), 0);
        snap();
        enable = 1'b1;
        step(1);
        chk("reen_wait", 32'(busy), 0);
        step(1);
        chk("reen_start", 32'(busy), 1);
        wait_done(60, dc);
        check_line("reen", 2, 20);
        chk("reen_offset", 32'(offset), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
